backing_mem: RTL and testbench
==============================

# backing_mem

Parametrised main-memory model behind the data cache: byte-addressable storage with a fixed, programmable access latency and a valid/ready request port. It serves whole-line refills on cache misses, byte/half/word store-through writes and full-line write-backs. One request is outstanding at a time, and completion is signalled by a one-cycle response pulse. It replaces the fixed 16-byte, fixed-delay data memory and adds line write-back, a proper handshake and an error flag.

## Interface
- ADDR_W, 12, byte-address width; storage depth is 2**ADDR_W bytes
- LINE_BYTES, 16, cache line size in bytes; power of two, 4..64
- LATENCY, 4, cycles from request acceptance to completion; must be >= 1
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, one reset domain (fixed decision)
- req_valid  in  1  request present
- req_ready  out  1  block idle, request will be accepted this cycle
- req_op  in  2  0 = line read, 1 = partial write, 2 = line write, 3 = reserved
- req_size  in  2  partial-write size: 1 = byte, 2 = half, 3 = word, 0 = illegal
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  partial-write data, little-endian, bits [7:0] to lowest address
- req_wline  in  LINE_BYTES*8  line-write data, byte 0 in bits [7:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; request was illegal and did not modify memory
- resp_rdata  out  LINE_BYTES*8  line-read data, byte 0 in bits [7:0]

## Operation
- States: IDLE and BUSY. A latency counter counts 0..LATENCY-1.
- IDLE: req_ready=1. When req_valid is high, the request is accepted at the clock edge. The block latches op, size, addr, wdata and wline, clears the counter and moves to BUSY.
- BUSY: req_ready=0. The counter increments each cycle. req_valid and all req_* inputs are ignored.
- Completion edge (counter = LATENCY-1):
  - memory access is performed
  - resp_valid<=1 and state<=IDLE
  - resp_err is set per the illegal-request rule below
- Line base = addr with its low log2(LINE_BYTES) bits cleared.
- Line read: resp_rdata <= bytes base..base+LINE_BYTES-1.
- Line write: bytes base..base+LINE_BYTES-1 <= wline.
- Partial write: writes size bytes (1, 2 or 4) starting at addr. Alignment is not required. Byte addresses wrap modulo 2**ADDR_W.
- Illegal request (op=3, or op=1 with size=0): no memory change, resp_rdata unchanged, resp_err=1.
- resp_rdata changes only on completion of a legal line read. It holds its value otherwise, including across writes.
- Storage is zero at simulation start. Reset does not clear storage.

## Timing
- Reset values:
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0
  - state IDLE, counter 0
- Reset asserted in BUSY aborts the pending request. No memory write occurs and no response is issued.
- Latency: if a request is accepted at edge E, then resp_valid is high in the cycle after edge E+LATENCY, for exactly one cycle.
- With LATENCY=1, the response follows acceptance directly.
- req_ready is high in the same cycle as resp_valid. A new request can be accepted at the edge that ends the resp_valid cycle.
- Peak throughput: one request per LATENCY+1 cycles.
- Memory writes become visible at the completion edge. A read accepted after a write's completion returns the new data.
- req_valid asserted while req_ready=0 has no effect. The requester must keep req_valid and its data stable until it sees ready.

## Test plan
- Reset, then read line at addr 0x000 -> after 4 cycles resp_valid pulse, resp_rdata=0, resp_err=0; req_ready=0 for exactly 4 cycles.
- Word write 0xDEADBEEF at 0x013, then line read at 0x01F -> read resp_rdata bytes 3..6 = EF BE AD DE, all other bytes 0.
- Byte write 0xA5 at 0xFFF, then word write 0x11223344 at 0xFFE -> wrap: memory 0xFFE=44, 0xFFF=33, 0x000=22, 0x001=11; confirm with reads of lines 0xFF0 and 0x000.
- Line write of pattern byte i = i+0x80 at 0x125 (base 0x120), then line read at 0x120 -> identical 128-bit pattern; neighbouring lines unchanged.
- Illegal op=3 and op=1 with size=0 -> resp_valid and resp_err both 1; previous resp_rdata retained; memory unchanged.
- Assert reset for 1 cycle at counter=2 of a word write to 0x040 -> no resp_valid, req_ready=1 the next cycle, subsequent read shows 0x040 unchanged.
- Back-to-back: second request held valid during BUSY -> accepted exactly in the resp_valid cycle; repeat for LATENCY=1 and LATENCY=7, and for LINE_BYTES=32.

Source files
------------

// File: rtl/backing_mem.sv
// Main-memory model behind the data cache: line refills, partial
// store-through writes and line write-backs with a fixed access latency.
module backing_mem #(
   parameter int ADDR_W     = 12,
   parameter int LINE_BYTES = 16,
   parameter int LATENCY    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [1:0]              req_op,
   input  logic [1:0]              req_size,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [31:0]             req_wdata,
   input  logic [LINE_BYTES*8-1:0] req_wline,
   output logic                    resp_valid,
   output logic                    resp_err,
   output logic [LINE_BYTES*8-1:0] resp_rdata
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int LW    = LINE_BYTES * 8;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        op_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [LW-1:0]     wline_q;
   logic              ready_q;
   logic              rvalid_q;
   logic              rerr_q;
   logic [LW-1:0]     rdata_q;
   logic [LW-1:0]     rdata_d;
   logic [ADDR_W-1:0] base_d;
   logic [2:0]        nbytes_d;
   logic              done;
   logic              illegal;
   logic              do_pwr;
   logic              do_lwr;

   // Storage powers up cleared and is deliberately untouched by reset.
   logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

   assign done    = (state_q == BUSY) && (cnt_q == CNT_LAST);
   assign illegal = (op_q == 2'd3) || (op_q == 2'd1 && size_q == 2'd0);
   assign do_pwr  = done && !reset && op_q == 2'd1 && size_q != 2'd0;
   assign do_lwr  = done && !reset && op_q == 2'd2;
   assign base_d  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   always_comb begin
      nbytes_d = 3'd0;
      unique case (size_q)
         2'd1:    nbytes_d = 3'd1;
         2'd2:    nbytes_d = 3'd2;
         2'd3:    nbytes_d = 3'd4;
         default: nbytes_d = 3'd0;
      endcase
   end

   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < LINE_BYTES; i++)
         rdata_d[8*i +: 8] = mem_q[base_d + ADDR_W'(i)];
   end

   // Partial writes may straddle the top of memory; the add wraps.
   always_ff @(posedge clk) begin
      if (do_pwr) begin
         for (int k = 0; k < 4; k++)
            if (k < int'(nbytes_d))
               mem_q[addr_q + ADDR_W'(k)] <= wdata_q[8*k +: 8];
      end
      if (do_lwr) begin
         for (int i = 0; i < LINE_BYTES; i++)
            mem_q[base_d + ADDR_W'(i)] <= wline_q[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  size_q  <= req_size;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  wline_q <= req_wline;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q == CNT_LAST) begin
                  state_q  <= IDLE;
                  ready_q  <= 1'b1;
                  rvalid_q <= 1'b1;
                  rerr_q   <= illegal;
                  if (op_q == 2'd0)
                     rdata_q <= rdata_d;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = rvalid_q;
   assign resp_err   = rerr_q;
   assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_backing_mem.sv
// Directed bench for backing_mem: default instance plus LATENCY=1 and
// LATENCY=7/LINE_BYTES=32 instances for the back-to-back throughput case.
module tb_backing_mem;

   localparam logic [127:0] PAT = 128'h8F8E8D8C8B8A89888786858483828180;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic         v1 = 1'b0;
   logic         v7 = 1'b0;
   logic [1:0]   req_op = '0;
   logic [1:0]   req_size = '0;
   logic [11:0]  req_addr = '0;
   logic [31:0]  req_wdata = '0;
   logic [127:0] req_wline = '0;
   logic [255:0] wline7 = '0;

   logic         req_ready, resp_valid, resp_err;
   logic [127:0] resp_rdata;
   logic         rdy1, rv1, re1;
   logic [127:0] rd1;
   logic         rdy7, rv7, re7;
   logic [255:0] rd7;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   backing_mem dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wline(req_wline), .resp_valid(resp_valid),
      .resp_err(resp_err), .resp_rdata(resp_rdata)
   );

   backing_mem #(.LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
      .req_op(req_op), .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wline(req_wline), .resp_valid(rv1),
      .resp_err(re1), .resp_rdata(rd1)
   );

   backing_mem #(.LATENCY(7), .LINE_BYTES(32)) dut7 (
      .clk(clk), .reset(reset), .req_valid(v7), .req_ready(rdy7),
      .req_op(req_op), .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wline(wline7), .resp_valid(rv7),
      .resp_err(re7), .resp_rdata(rd7)
   );

   task automatic do_req(input logic [1:0] op, input logic [1:0] sz,
                         input logic [11:0] a, input logic [31:0] wd,
                         input logic [127:0] wl, output logic [127:0] rd,
                         output logic err, output int lat, output int nbusy);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_size  = sz;
      req_addr  = a;
      req_wdata = wd;
      req_wline = wl;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      nbusy = 0;
      while (!resp_valid && lat < 20) begin
         if (!req_ready) nbusy++;
         lat++;
         @(negedge clk);
      end
      rd  = resp_rdata;
      err = resp_err;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      nvec++; if (req_ready !== 1'b1) begin nerr++;
         $display("FAIL rst_ready: got %b want 1", req_ready); end
      nvec++; if (resp_valid !== 1'b0) begin nerr++;
         $display("FAIL rst_valid: got %b want 0", resp_valid); end
      nvec++; if (resp_err !== 1'b0) begin nerr++;
         $display("FAIL rst_err: got %b want 0", resp_err); end
      nvec++; if (resp_rdata !== 128'h0) begin nerr++;
         $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
      reset = 1'b0;
   endtask

   task automatic test_read_zero();
      logic [127:0] rd; logic err; int lat, nb;
      do_req(2'd0, 2'd0, 12'h000, 32'h0, 128'h0, rd, err, lat, nb);
      nvec++; if (lat !== 4) begin nerr++;
         $display("FAIL rd0_lat: got %0d want 4", lat); end
      nvec++; if (nb !== 4) begin nerr++;
         $display("FAIL rd0_busy: got %0d want 4", nb); end
      nvec++; if (rd !== 128'h0 || err !== 1'b0) begin nerr++;
         $display("FAIL rd0_data: got %h/%b want 0/0", rd, err); end
      @(negedge clk);
      nvec++; if (resp_valid !== 1'b0) begin nerr++;
         $display("FAIL rd0_pulse: got %b want 0", resp_valid); end
   endtask

   task automatic test_word_write();
      logic [127:0] rd; logic err; int lat, nb;
      do_req(2'd1, 2'd3, 12'h013, 32'hDEADBEEF, 128'h0, rd, err, lat, nb);
      nvec++; if (err !== 1'b0 || lat !== 4) begin nerr++;
         $display("FAIL ww_resp: got err %b lat %0d want 0 4", err, lat); end
      nvec++; if (rd !== 128'h0) begin nerr++;
         $display("FAIL ww_hold: got %h want 0", rd); end
      do_req(2'd0, 2'd0, 12'h01F, 32'h0, 128'h0, rd, err, lat, nb);
      nvec++; if (rd !== 128'h0000_0000_0000_0000_00DE_ADBE_EF00_0000) begin
         nerr++; $display("FAIL ww_read: got %h", rd); end
   endtask

   task automatic test_wrap();
      logic [127:0] rd; logic err; int lat, nb;
      do_req(2'd1, 2'd1, 12'hFFF, 32'h000000A5, 128'h0, rd, err, lat, nb);
      do_req(2'd1, 2'd3, 12'hFFE, 32'h11223344, 128'h0, rd, err, lat, nb);
      do_req(2'd0, 2'd0, 12'hFF0, 32'h0, 128'h0, rd, err, lat, nb);
      nvec++; if (rd !== 128'h3344_0000_0000_0000_0000_0000_0000_0000) begin
         nerr++; $display("FAIL wrap_hi: got %h", rd); end
      do_req(2'd0, 2'd0, 12'h000, 32'h0, 128'h0, rd, err, lat, nb);
      nvec++; if (rd !== 128'h1122) begin nerr++;
         $display("FAIL wrap_lo: got %h want 1122", rd); end
   endtask

   task automatic test_line_write();
      logic [127:0] rd; logic err; int lat, nb;
      do_req(2'd2, 2'd0, 12'h125, 32'h0, PAT, rd, err, lat, nb);
      nvec++; if (err !== 1'b0 || lat !== 4) begin nerr++;
         $display("FAIL lw_resp: got err %b lat %0d", err, lat); end
      do_req(2'd0, 2'd0, 12'h110, 32'h0, 128'h0, rd, err, lat, nb);
      nvec++; if (rd !== 128'h0) begin nerr++;
         $display("FAIL lw_below: got %h want 0", rd); end
      do_req(2'd0, 2'd0, 12'h130, 32'h0, 128'h0, rd, err, lat, nb);
      nvec++; if (rd !== 128'h0) begin nerr++;
         $display("FAIL lw_above: got %h want 0", rd); end
      do_req(2'd0, 2'd0, 12'h120, 32'h0, 128'h0, rd, err, lat, nb);
      nvec++; if (rd !== PAT) begin nerr++;
         $display("FAIL lw_read: got %h want %h", rd, PAT); end
   endtask

   task automatic test_illegal();
      logic [127:0] rd; logic err; int lat, nb;
      do_req(2'd3, 2'd3, 12'h120, 32'hFFFFFFFF, '1, rd, err, lat, nb);
      nvec++; if (err !== 1'b1 || lat !== 4) begin nerr++;
         $display("FAIL ill_op3: got err %b lat %0d want 1 4", err, lat); end
      nvec++; if (rd !== PAT) begin nerr++;
         $display("FAIL ill_op3_hold: got %h want %h", rd, PAT); end
      do_req(2'd1, 2'd0, 12'h124, 32'hFFFFFFFF, '1, rd, err, lat, nb);
      nvec++; if (err !== 1'b1 || rd !== PAT) begin nerr++;
         $display("FAIL ill_sz0: got %b/%h want 1/%h", err, rd, PAT); end
      do_req(2'd0, 2'd0, 12'h120, 32'h0, 128'h0, rd, err, lat, nb);
      nvec++; if (err !== 1'b0 || rd !== PAT) begin nerr++;
         $display("FAIL ill_mem: got %b/%h want 0/%h", err, rd, PAT); end
   endtask

   task automatic test_reset_abort();
      logic [127:0] rd; logic err; int lat, nb; int seen;
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd1; req_size = 2'd3;
      req_addr = 12'h040; req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      nvec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin nerr++;
         $display("FAIL abort_state: got rdy %b vld %b want 1 0",
                  req_ready, resp_valid); end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      nvec++; if (seen !== 0) begin nerr++;
         $display("FAIL abort_resp: got %0d pulses want 0", seen); end
      do_req(2'd0, 2'd0, 12'h040, 32'h0, 128'h0, rd, err, lat, nb);
      nvec++; if (rd !== 128'h0 || lat !== 4) begin nerr++;
         $display("FAIL abort_mem: got %h lat %0d want 0 4", rd, lat); end
   endtask

   task automatic test_back_to_back();
      logic e4, e1, e7;
      @(negedge clk);
      req_op = 2'd0; req_size = 2'd0; req_addr = 12'h120;
      req_valid = 1'b1; v1 = 1'b1; v7 = 1'b1;
      for (int j = 0; j < 24; j++) begin
         @(posedge clk);
         @(negedge clk);
         e4 = (j >= 4) && ((j - 4) % 5 == 0);
         e1 = (j >= 1) && ((j - 1) % 2 == 0);
         e7 = (j >= 7) && ((j - 7) % 8 == 0);
         nvec++; if ({req_ready, resp_valid} !== {e4, e4}) begin nerr++;
            $display("FAIL b2b_l4 c%0d: got %b%b want %b%b",
                     j, req_ready, resp_valid, e4, e4); end
         nvec++; if ({rdy1, rv1} !== {e1, e1}) begin nerr++;
            $display("FAIL b2b_l1 c%0d: got %b%b want %b%b",
                     j, rdy1, rv1, e1, e1); end
         nvec++; if ({rdy7, rv7} !== {e7, e7}) begin nerr++;
            $display("FAIL b2b_l7 c%0d: got %b%b want %b%b",
                     j, rdy7, rv7, e7, e7); end
         if (e4) begin
            nvec++; if (resp_rdata !== PAT || resp_err !== 1'b0) begin
               nerr++; $display("FAIL b2b_data c%0d: got %h", j, resp_rdata); end
         end
         if (e1) begin
            nvec++; if (rd1 !== 128'h0 || re1 !== 1'b0) begin
               nerr++; $display("FAIL b2b_d1 c%0d: got %h", j, rd1); end
         end
         if (e7) begin
            nvec++; if (rd7 !== 256'h0 || re7 !== 1'b0) begin
               nerr++; $display("FAIL b2b_d7 c%0d: got %h", j, rd7); end
         end
      end
      req_valid = 1'b0; v1 = 1'b0; v7 = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_read_zero();
      test_word_write();
      test_wrap();
      test_line_write();
      test_illegal();
      test_reset_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
